// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_pkg
// Purpose : Shared constants and helpers for the RAM port arbiter.
//           LOCK_MAX    - longest run of consecutive grants a locking
//                         requester may hold before arbitration resumes.
//           LOCK_CNT_W  - width of the saturating lock run counter.
//           clog2()     - pointer width helper (never returns less than 1).
//           RAM_ARB_SLICE(vec, idx, w) - selects field idx of width w from a
//                         packed per-requester vector.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================

`ifndef RAM_ARB_PKG_SV
`define RAM_ARB_PKG_SV

`define RAM_ARB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package ram_arb_pkg;

   localparam int LOCK_MAX   = 16;
   localparam int LOCK_CNT_W = 5;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin priority selector. The search starts
//           one position after the last winner and wraps; the first
//           asserted request wins.
// Ports   : req_i   [NREQ]  - request vector
//           last_i  [PTR_W] - index of the previous winner
//           gnt_o   [NREQ]  - one-hot grant (all zero when req_i is zero)
//           idx_o   [PTR_W] - encoded index of the grant (0 when none)
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] last_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [PTR_W-1:0] idx_o
);

   logic             w_found;
   logic [PTR_W-1:0] w_cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      // Offsets 1..NREQ visit every requester once, ending on last_i itself
      // so a lone requester that also won last time is still granted.
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = PTR_W'((int'(last_i) + k) % NREQ);
         if (!w_found && req_i[w_cand]) begin
            w_found        = 1'b1;
            gnt_o[w_cand]  = 1'b1;
            idx_o          = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_port_arbiter
// Purpose : Shares one port of a single-clock dual-port block RAM between
//           NREQ requesters. One single-word request is granted per cycle
//           (round robin, with an optional bounded burst lock), the RAM port
//           is driven from registers one cycle later, and read data returns
//           to the requester two cycles after its grant.
// Ports   : clk          - system clock
//           reset        - synchronous active-high reset
//           req          [NREQ]       - request valid, held until granted
//           req_we       [NREQ]       - 1 = write, 0 = read
//           req_lock     [NREQ]       - request to keep the grant next cycle
//           req_address  [NREQ*DEPTH] - packed addresses
//           req_din      [NREQ*WIDTH] - packed write data
//           gnt          [NREQ]       - one-hot grant, same cycle as accept
//           rvalid       [NREQ]       - one-hot read data valid
//           rdata        [WIDTH]      - read data, qualified by rvalid
//           ram_we/ram_oe/ram_address/ram_din - registered RAM port drive
//           ram_dout     [WIDTH]      - RAM read data (registered in RAM)
//           busy         - a read is somewhere in the return pipeline
// Revision: 1.0 - initial release
// ============================================================================
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 10,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ-1:0]        req_lock,
   input  logic [NREQ*DEPTH-1:0]  req_address,
   input  logic [NREQ*WIDTH-1:0]  req_din,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [WIDTH-1:0]       rdata,
   output logic                   ram_we,
   output logic                   ram_oe,
   output logic [DEPTH-1:0]       ram_address,
   output logic [WIDTH-1:0]       ram_din,
   input  logic [WIDTH-1:0]       ram_dout,
   output logic                   busy
);

   localparam int                    PTR_W      = clog2(NREQ);
   localparam logic [PTR_W-1:0]      LAST_RST   = PTR_W'(NREQ - 1);
   localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX);

   // Arbitration state
   logic [PTR_W-1:0]      last_q,     last_d;
   logic                  lock_vld_q, lock_vld_d;
   logic [PTR_W-1:0]      lock_idx_q, lock_idx_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   // Issue stage
   logic                  ram_we_q,      ram_we_d;
   logic                  ram_oe_q,      ram_oe_d;
   logic [DEPTH-1:0]      ram_address_q, ram_address_d;
   logic [WIDTH-1:0]      ram_din_q,     ram_din_d;

   // Read return pipeline: one-hot requester id per stage
   logic [NREQ-1:0]       rd_s1_q, rd_s1_d;
   logic [NREQ-1:0]       rd_s2_q;

   // Combinational arbitration results
   logic [NREQ-1:0]       w_rr_gnt;
   logic [PTR_W-1:0]      w_rr_idx;
   logic                  w_lock_hit;
   logic [NREQ-1:0]       w_gnt;
   logic [PTR_W-1:0]      w_win_idx;
   logic                  w_accept;

   // Granted requester's fields
   logic [DEPTH-1:0]      w_addr_arr [NREQ];
   logic [WIDTH-1:0]      w_din_arr  [NREQ];
   logic                  w_sel_we;
   logic                  w_sel_lock;
   logic [DEPTH-1:0]      w_sel_addr;
   logic [WIDTH-1:0]      w_sel_din;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_addr_arr[gi] = `RAM_ARB_SLICE(req_address, gi, DEPTH);
         assign w_din_arr[gi]  = `RAM_ARB_SLICE(req_din, gi, WIDTH);
      end
   endgenerate

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (w_rr_gnt),
      .idx_o  (w_rr_idx)
   );

   // A live lock bypasses the round-robin search for as long as the owner
   // keeps requesting; the run limit is enforced when the lock is recorded.
   assign w_lock_hit = lock_vld_q & req[lock_idx_q];

   always_comb begin
      w_gnt     = '0;
      w_win_idx = w_rr_idx;
      if (!reset) begin
         if (w_lock_hit) begin
            w_gnt[lock_idx_q] = 1'b1;
            w_win_idx         = lock_idx_q;
         end else begin
            w_gnt = w_rr_gnt;
         end
      end
   end

   assign w_accept = |w_gnt;

   // AND-OR style selection; w_gnt is one-hot so at most one term is live.
   always_comb begin
      w_sel_we   = 1'b0;
      w_sel_lock = 1'b0;
      w_sel_addr = '0;
      w_sel_din  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_sel_we   = req_we[i];
            w_sel_lock = req_lock[i];
            w_sel_addr = w_addr_arr[i];
            w_sel_din  = w_din_arr[i];
         end
      end
   end

   always_comb begin
      last_d        = last_q;
      lock_vld_d    = 1'b0;
      lock_idx_d    = lock_idx_q;
      lock_cnt_d    = '0;
      ram_we_d      = 1'b0;
      ram_oe_d      = 1'b0;
      ram_address_d = ram_address_q;
      ram_din_d     = ram_din_q;
      rd_s1_d       = '0;

      if (w_accept) begin
         last_d     = w_win_idx;
         lock_idx_d = w_win_idx;
         // Count consecutive grants of the current lock run; a grant won
         // through normal arbitration starts a new run at one.
         if (w_lock_hit) begin
            lock_cnt_d = (lock_cnt_q >= LOCK_LIMIT) ? LOCK_LIMIT : lock_cnt_q + 1'b1;
         end else begin
            lock_cnt_d = LOCK_CNT_W'(1);
         end
         // Once the run reaches the limit the next cycle arbitrates normally
         // with this requester as last winner.
         lock_vld_d    = w_sel_lock && (lock_cnt_d < LOCK_LIMIT);

         ram_we_d      = w_sel_we;
         ram_oe_d      = ~w_sel_we;
         ram_address_d = w_sel_addr;
         ram_din_d     = w_sel_din;
         if (!w_sel_we) begin
            rd_s1_d = w_gnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q        <= LAST_RST;
         lock_vld_q    <= 1'b0;
         lock_idx_q    <= '0;
         lock_cnt_q    <= '0;
         ram_we_q      <= 1'b0;
         ram_oe_q      <= 1'b0;
         ram_address_q <= '0;
         ram_din_q     <= '0;
         rd_s1_q       <= '0;
         rd_s2_q       <= '0;
      end else begin
         last_q        <= last_d;
         lock_vld_q    <= lock_vld_d;
         lock_idx_q    <= lock_idx_d;
         lock_cnt_q    <= lock_cnt_d;
         ram_we_q      <= ram_we_d;
         ram_oe_q      <= ram_oe_d;
         ram_address_q <= ram_address_d;
         ram_din_q     <= ram_din_d;
         rd_s1_q       <= rd_s1_d;
         rd_s2_q       <= rd_s1_q;
      end
   end

   assign gnt         = w_gnt;
   assign ram_we      = ram_we_q;
   assign ram_oe      = ram_oe_q;
   assign ram_address = ram_address_q;
   assign ram_din     = ram_din_q;
   // The RAM registers the word at the edge that ends the issue cycle, so
   // its output lines up with the second pipeline stage without a mux.
   assign rvalid      = rd_s2_q;
   assign rdata       = ram_dout;
   assign busy        = (|rd_s1_q) | (|rd_s2_q);

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_port_arbiter
// Purpose : Self-checking bench for ram_port_arbiter. A behavioural RAM sits
//           on the RAM port; a reference model predicts grants, the RAM port
//           drive, read returns and busy on every cycle, with directed
//           scenarios followed by randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

   localparam int NREQ     = 4;
   localparam int DEPTH    = 10;
   localparam int WIDTH    = 32;
   localparam int NCYC     = 4096;
   localparam int LOCK_MAX = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        req_we;
   logic [NREQ-1:0]        req_lock;
   logic [NREQ*DEPTH-1:0]  req_address;
   logic [NREQ*WIDTH-1:0]  req_din;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [WIDTH-1:0]       rdata;
   logic                   ram_we;
   logic                   ram_oe;
   logic [DEPTH-1:0]       ram_address;
   logic [WIDTH-1:0]       ram_din;
   logic [WIDTH-1:0]       ram_dout;
   logic                   busy;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .NREQ  (NREQ),
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_we      (req_we),
      .req_lock    (req_lock),
      .req_address (req_address),
      .req_din     (req_din),
      .gnt         (gnt),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .ram_we      (ram_we),
      .ram_oe      (ram_oe),
      .ram_address (ram_address),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
      .busy        (busy)
   );

   function automatic logic [WIDTH-1:0] init_val(input int a);
      return WIDTH'(32'hA5C3_0000 ^ (a * 32'h0001_0203));
   endfunction

   // Behavioural block RAM with a registered read port
   logic [WIDTH-1:0] ram [0:(1<<DEPTH)-1];
   initial begin
      for (int a = 0; a < (1 << DEPTH); a++) ram[a] = init_val(a);
   end
   always @(posedge clk) begin
      if (ram_we) ram[ram_address] <= ram_din;
      if (ram_oe) ram_dout <= ram[ram_address];
   end

   // Held request fields per requester
   logic             r_we   [NREQ];
   logic             r_lock [NREQ];
   logic [DEPTH-1:0] r_addr [NREQ];
   logic [WIDTH-1:0] r_din  [NREQ];

   // Reference model state
   int               checks = 0;
   int               errors = 0;
   int               cyc    = 0;
   bit               m_known = 1'b0;
   int               m_last, m_lock, m_run, m_win;
   logic [DEPTH-1:0] m_addr;
   logic [WIDTH-1:0] m_din;
   logic [WIDTH-1:0] mem_ref [0:(1<<DEPTH)-1];

   // Expected registered outputs per cycle
   logic             e_we   [NCYC];
   logic             e_oe   [NCYC];
   logic [DEPTH-1:0] e_addr [NCYC];
   logic [WIDTH-1:0] e_din  [NCYC];
   logic [WIDTH-1:0] e_rd   [NCYC];
   logic [NREQ-1:0]  e_rv   [NCYC];
   logic [NREQ-1:0]  e_s1   [NCYC];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_we[i]                      = r_we[i];
         req_lock[i]                    = r_lock[i];
         req_address[i*DEPTH +: DEPTH]  = r_addr[i];
         req_din[i*WIDTH +: WIDTH]      = r_din[i];
      end
   endtask

   // Lock owner keeps the port while it requests; otherwise the first
   // requester after the last winner, wrapping, wins.
   function automatic int model_pick();
      if (m_lock >= 0 && req[m_lock]) return m_lock;
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (m_last + k) % NREQ;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic sample();
      logic [NREQ-1:0] eg;
      @(negedge clk);
      m_win = reset ? -1 : model_pick();
      eg = '0;
      if (m_win >= 0) eg[m_win] = 1'b1;
      chk("gnt", 64'(gnt), 64'(eg));
      if (m_known) begin
         chk("ram_we",      64'(ram_we),      64'(e_we[cyc]));
         chk("ram_oe",      64'(ram_oe),      64'(e_oe[cyc]));
         chk("ram_address", 64'(ram_address), 64'(e_addr[cyc]));
         chk("ram_din",     64'(ram_din),     64'(e_din[cyc]));
         chk("rvalid",      64'(rvalid),      64'(e_rv[cyc]));
         chk("busy",        64'(busy),        64'((e_rv[cyc] != '0) || (e_s1[cyc] != '0)));
         if (e_rv[cyc] != '0) chk("rdata", 64'(rdata), 64'(e_rd[cyc]));
      end
   endtask

   task automatic advance();
      logic [NREQ-1:0] oh;
      @(posedge clk);
      oh = '0;
      if (reset) begin
         m_known       = 1'b1;
         m_last        = NREQ - 1;
         m_lock        = -1;
         m_run         = 0;
         m_addr        = '0;
         m_din         = '0;
         e_we[cyc+1]   = 1'b0;
         e_oe[cyc+1]   = 1'b0;
         e_rv[cyc+1]   = '0;
         e_rv[cyc+2]   = '0;
         e_s1[cyc+1]   = '0;
      end else if (m_win >= 0) begin
         oh[m_win]   = 1'b1;
         m_run       = (m_win == m_lock) ? m_run + 1 : 1;
         m_lock      = (req_lock[m_win] && m_run < LOCK_MAX) ? m_win : -1;
         m_last      = m_win;
         m_addr      = r_addr[m_win];
         m_din       = r_din[m_win];
         e_we[cyc+1] = r_we[m_win];
         e_oe[cyc+1] = !r_we[m_win];
         if (r_we[m_win]) begin
            mem_ref[m_addr] = m_din;
            e_rv[cyc+2]     = '0;
            e_s1[cyc+1]     = '0;
         end else begin
            e_rd[cyc+2]     = mem_ref[m_addr];
            e_rv[cyc+2]     = oh;
            e_s1[cyc+1]     = oh;
         end
      end else begin
         m_lock      = -1;
         m_run       = 0;
         e_we[cyc+1] = 1'b0;
         e_oe[cyc+1] = 1'b0;
         e_rv[cyc+2] = '0;
         e_s1[cyc+1] = '0;
      end
      e_addr[cyc+1] = m_addr;
      e_din[cyc+1]  = m_din;
      cyc++;
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   int n1;

   initial begin
      for (int a = 0; a < (1 << DEPTH); a++) mem_ref[a] = init_val(a);
      for (int i = 0; i < NREQ; i++) begin
         r_we[i] = 1'b0; r_lock[i] = 1'b0; r_addr[i] = '0; r_din[i] = '0;
      end
      reset = 1'b1;
      req   = '0;
      drive();
      @(posedge clk);
      #1;

      // Reset held two cycles; the second checks the reset state
      tick();
      tick();
      reset = 1'b0;

      // All four reading: strict rotation starting at requester 0
      req = '1;
      for (int i = 0; i < NREQ; i++) r_addr[i] = DEPTH'(16 + i);
      drive();
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("prio_order", 64'(gnt), 64'(1 << (k % NREQ)));
         advance();
      end
      req = '0;
      drive();
      repeat (3) tick();

      // Write then read of the same word on consecutive cycles
      req = 4'b0001; r_we[0] = 1'b1; r_addr[0] = DEPTH'(5); r_din[0] = 32'hDEAD_BEEF;
      drive();
      tick();
      req = 4'b0100; r_we[2] = 1'b0; r_addr[2] = DEPTH'(5);
      drive();
      tick();
      req = '0;
      drive();
      tick();
      sample();
      chk("wr_rd_rvalid", 64'(rvalid), 64'(4'b0100));
      chk("wr_rd_rdata",  64'(rdata),  64'(32'hDEAD_BEEF));
      advance();
      repeat (2) tick();

      // Lock burst: requester 1 locks for 20 reads against requester 3
      r_we[1] = 1'b0; r_lock[1] = 1'b1; r_addr[1] = DEPTH'(32);
      r_we[3] = 1'b0; r_lock[3] = 1'b0; r_addr[3] = DEPTH'(48);
      req = 4'b1010;
      drive();
      n1 = 0;
      for (int k = 0; k < 22; k++) begin
         int ex;
         ex = (k == 0 || k == 17) ? 3 : 1;
         sample();
         chk("lock_seq", 64'(gnt), 64'(1 << ex));
         advance();
         if (m_win == 1) n1++;
         if (n1 == 20) begin
            req[1] = 1'b0; r_lock[1] = 1'b0;
            drive();
         end
      end
      req = '0;
      drive();
      repeat (3) tick();

      // Sparse: requester 2 alone, one pulse every third cycle
      for (int k = 0; k < 9; k++) begin
         req = (k % 3 == 0) ? 4'b0100 : 4'b0000;
         r_we[2] = ((k / 3) % 2) == 1; r_addr[2] = DEPTH'(k); r_din[2] = $urandom;
         drive();
         sample();
         chk("sparse_gnt", 64'(gnt), 64'((k % 3 == 0) ? 4'b0100 : 4'b0000));
         advance();
      end

      // Reset in the cycle after a read is accepted
      req = 4'b0001; r_we[0] = 1'b0; r_lock[0] = 1'b0; r_addr[0] = DEPTH'(7);
      drive();
      tick();
      reset = 1'b1; req = '0;
      drive();
      sample();
      chk("rst_gnt_zero", 64'(gnt), 64'(0));
      advance();
      reset = 1'b0; req = '1;
      for (int i = 0; i < NREQ; i++) begin r_we[i] = 1'b0; r_lock[i] = 1'b0; end
      drive();
      sample();
      chk("rst_no_rvalid", 64'(rvalid), 64'(0));
      chk("rst_ram_oe",    64'(ram_oe),  64'(0));
      chk("rst_first_gnt", 64'(gnt),     64'(4'b0001));
      advance();
      req = '0;
      drive();
      repeat (3) tick();

      // Randomized traffic with requesters holding until granted
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 99) < (r_lock[i] ? 90 : 35)) begin
               req[i]    = 1'b1;
               r_we[i]   = $urandom_range(0, 1) == 1;
               r_addr[i] = DEPTH'($urandom_range(0, 15));
               r_din[i]  = $urandom;
               r_lock[i] = $urandom_range(0, 3) == 0;
            end
         end
         reset = ($urandom_range(0, 249) == 0);
         drive();
         sample();
         advance();
         if (m_win >= 0) req[m_win] = 1'b0;
      end
      reset = 1'b0;
      req   = '0;
      drive();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
